// File: rtl/result_demux.sv
// Registered 1-to-8 result demultiplexer: steers one producer word into one of
// eight single-entry holding registers, each drained independently by valid/ready.
module result_demux #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [(2**SEL_W)*WIDTH-1:0] out_data,
    output logic [(2**SEL_W)-1:0]     out_valid,
    input  logic [(2**SEL_W)-1:0]     out_ready,
    output logic [15:0]               xfer_cnt
);

    localparam int NCH = 2**SEL_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t         state_r     [NCH];
    chan_state_t         state_nxt_s [NCH];
    logic [WIDTH-1:0]    data_r      [NCH];
    logic [NCH-1:0]      full_s;
    logic [NCH-1:0]      wr_en_s;
    logic [NCH-1:0]      drain_s;
    logic                in_ready_s;
    logic                accept_s;
    logic [15:0]         xfer_cnt_r;

    // Only the addressed channel gates acceptance; in_valid never feeds in_ready.
    always_comb begin
        in_ready_s = !full_s[in_sel] || out_ready[in_sel];
        accept_s   = in_valid && in_ready_s;
    end

    // Per-channel write enable and drain qualifiers.
    always_comb begin
        wr_en_s = '0;
        drain_s = '0;
        for (int i = 0; i < NCH; i++) begin
            full_s[i]  = (state_r[i] == FULL);
            if (accept_s && (in_sel == SEL_W'(i))) begin
                wr_en_s[i] = 1'b1;
            end else begin
                wr_en_s[i] = 1'b0;
            end
            drain_s[i] = full_s[i] && out_ready[i];
        end
    end

    // Channel FSM next state: a same-cycle accept overrides a drain.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_nxt_s[i] = state_r[i];
            case (state_r[i])
                EMPTY: begin
                    if (wr_en_s[i]) begin
                        state_nxt_s[i] = FULL;
                    end else begin
                        state_nxt_s[i] = EMPTY;
                    end
                end
                FULL: begin
                    if (wr_en_s[i]) begin
                        state_nxt_s[i] = FULL;
                    end else if (drain_s[i]) begin
                        state_nxt_s[i] = EMPTY;
                    end else begin
                        state_nxt_s[i] = FULL;
                    end
                end
                default: state_nxt_s[i] = EMPTY;
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= state_nxt_s[i];
            end
        end
    end

    // Holding registers; a drained word stays put until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_en_s[i]) begin
                    data_r[i] <= in_data;
                end else begin
                    data_r[i] <= data_r[i];
                end
            end
        end
    end

    // Accepted-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_r <= 16'h0000;
        end else if (accept_s) begin
            xfer_cnt_r <= xfer_cnt_r + 16'h0001;
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_out
            assign out_data[g*WIDTH +: WIDTH] = data_r[g];
            assign out_valid[g]               = (state_r[g] == FULL);
        end
    endgenerate

    assign in_ready = in_ready_s;
    assign xfer_cnt = xfer_cnt_r;

endmodule
